seq_detect_ctrl: RTL and testbench

Run controller for serial sequence detection. Accepts a programmable pattern of 1..MAXW bits, an overlap mode and an observation window. It scans a `bit_valid`-qualified serial stream for the window and reports per-match pulses, a saturating match count and the index of the first match. It sits between the stimulus/bitstream source and status logic, and replaces the fixed-pattern Mealy detectors with one configurable, start/done-sequenced engine.

---
 rtl/seq_ctrl_pkg.sv | 21 ++
 rtl/seq_match_core.sv | 51 +++++
 rtl/seq_detect_ctrl.sv | 146 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types, default widths and config validation for the sequence-detect run controller.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_MAXW    = 8;
    localparam int unsigned DEF_LENW    = 4;
    localparam int unsigned DEF_CNTW    = 8;
    localparam int unsigned DEF_WINW    = 16;
    localparam int unsigned DEF_TIMEOUT = 64;

    function automatic logic cfg_valid(input int unsigned len, input int unsigned window,
                                       input int unsigned maxw);
        return (len != 0) && (len <= maxw) && (window != 0);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register with fill tracking and a length-masked pattern compare.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned MAXW = DEF_MAXW,
    parameter int unsigned LENW = DEF_LENW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            shift,
    input  logic            clr,
    input  logic            bit_in,
    input  logic [LENW-1:0] len,
    input  logic [MAXW-1:0] pattern,
    input  logic            overlap,
    output logic            match
);

    logic [MAXW-1:0] hist_q;
    logic [MAXW-1:0] hist_nxt;
    logic [LENW-1:0] fill_q;
    logic [LENW-1:0] fill_nxt;
    logic            eq;

    // Compare against the post-shift history so the completing bit counts in its own cycle.
    always_comb begin
        hist_nxt = {hist_q[MAXW-2:0], bit_in};
        fill_nxt = (fill_q == LENW'(MAXW)) ? fill_q : fill_q + 1'b1;
        eq       = 1'b1;
        for (int unsigned i = 0; i < MAXW; i++) begin
            if ((LENW'(i) < len) && (hist_nxt[i] != pattern[i])) begin
                eq = 1'b0;
            end
        end
        match = shift && (fill_nxt >= len) && eq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist_nxt;
            fill_q <= (match && !overlap) ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Start/done sequenced configurable serial pattern detector with match count and first-match index.
// Optional idle timeout enabled by defining SEQ_CTRL_TIMEOUT_EN.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned MAXW    = DEF_MAXW,
    parameter int unsigned LENW    = DEF_LENW,
    parameter int unsigned CNTW    = DEF_CNTW,
    parameter int unsigned WINW    = DEF_WINW,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [MAXW-1:0] cfg_pattern,
    input  logic [LENW-1:0] cfg_len,
    input  logic            cfg_overlap,
    input  logic [WINW-1:0] cfg_window,
    input  logic            bit_valid,
    input  logic            bit_in,
    output logic            busy,
    output logic            detected,
    output logic [CNTW-1:0] match_count,
    output logic [WINW-1:0] first_idx,
    output logic            first_vld,
    output logic            done,
    output logic            timeout
);

    state_t          state, state_nxt;
    logic [MAXW-1:0] pat_q;
    logic [LENW-1:0] len_q;
    logic            ov_q;
    logic [WINW-1:0] win_q;
    logic [WINW-1:0] idx_q;
    logic            cfg_ok;
    logic            accept;
    logic            shift;
    logic            last;
    logic            match;
    logic            expire;

    assign cfg_ok = cfg_valid(32'(cfg_len), 32'(cfg_window), MAXW);
    assign accept = (state == IDLE) && start;
    assign shift  = (state == RUN) && bit_valid;
    assign last   = shift && (idx_q == win_q - 1'b1);

    seq_match_core #(
        .MAXW (MAXW),
        .LENW (LENW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .clr     (accept),
        .bit_in  (bit_in),
        .len     (len_q),
        .pattern (pat_q),
        .overlap (ov_q),
        .match   (match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cfg_ok ? RUN : DONE;
            RUN:     if (last || expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q       <= '0;
            len_q       <= '0;
            ov_q        <= 1'b0;
            win_q       <= '0;
            idx_q       <= '0;
            detected    <= 1'b0;
            match_count <= '0;
            first_idx   <= '0;
            first_vld   <= 1'b0;
        end else begin
            detected <= shift && match;
            if (accept) begin
                pat_q       <= cfg_pattern;
                len_q       <= cfg_len;
                ov_q        <= cfg_overlap;
                win_q       <= cfg_window;
                idx_q       <= '0;
                match_count <= '0;
                first_idx   <= '0;
                first_vld   <= 1'b0;
            end else if (shift) begin
                idx_q <= idx_q + 1'b1;
                if (match) begin
                    if (match_count != '1) match_count <= match_count + 1'b1;
                    if (!first_vld) begin
                        first_idx <= idx_q;
                        first_vld <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned IDLEW = $clog2(TIMEOUT + 1);
    logic [IDLEW-1:0] idle_q;
    logic             timeout_q;

    assign expire  = (state == RUN) && !bit_valid && (idle_q == IDLEW'(TIMEOUT - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state == RUN) begin
            if (bit_valid)   idle_q    <= '0;
            else if (expire) timeout_q <= 1'b1;
            else             idle_q    <= idle_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign expire         = 1'b0;
    assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized self-checking bench for seq_detect_ctrl against a bit-queue reference model.
`timescale 1ns/1ps
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic [15:0] cfg_window;
    logic        bit_valid;
    logic        bit_in;
    logic        busy, detected, first_vld, done, timeout;
    logic [7:0]  match_count;
    logic [15:0] first_idx;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit          stim[$];
    bit          m_hist[$];
    int unsigned m_seg, m_count, m_first;
    bit          m_fvld;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .MAXW    (8),
        .LENW    (4),
        .CNTW    (8),
        .WINW    (16),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_window  (cfg_window),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .busy        (busy),
        .detected    (detected),
        .match_count (match_count),
        .first_idx   (first_idx),
        .first_vld   (first_vld),
        .done        (done),
        .timeout     (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A match completes at bit i when the last len bits equal the pattern (MSB first) and,
    // in non-overlap mode, none of them belong to an earlier match.
    function automatic bit model_bit(input bit b, input logic [7:0] pat, input int unsigned len,
                                     input bit ov);
        int unsigned i;
        bit          hit;
        m_hist.push_back(b);
        i   = m_hist.size() - 1;
        hit = (i + 1 - m_seg) >= len;
        for (int unsigned j = 0; j < len && hit; j++) begin
            if (m_hist[i - j] != pat[j]) hit = 1'b0;
        end
        if (hit) begin
            if (m_count < 255) m_count++;
            if (!m_fvld) begin
                m_fvld  = 1'b1;
                m_first = i;
            end
            if (!ov) m_seg = i + 1;
        end
        return hit;
    endfunction

    task automatic do_start(input logic [7:0] pat, input int unsigned len, input bit ov,
                            input int unsigned win);
        cfg_pattern = pat;
        cfg_len     = 4'(len);
        cfg_overlap = ov;
        cfg_window  = 16'(win);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic run_case(input string nm, input logic [7:0] pat, input int unsigned len,
                            input bit ov, input int unsigned win, input int unsigned max_gap);
        bit exp_det;
        m_hist.delete();
        m_seg = 0; m_count = 0; m_first = 0; m_fvld = 1'b0;
        do_start(pat, len, ov, win);
        check({nm, " busy@start"}, busy, 1);
        check({nm, " cnt@start"}, match_count, 0);
        check({nm, " fvld@start"}, first_vld, 0);
        for (int unsigned i = 0; i < win; i++) begin
            int unsigned gaps = (max_gap != 0) ? $urandom_range(0, max_gap) : 0;
            for (int unsigned g = 0; g < gaps; g++) begin
                bit_valid   = 1'b0;
                bit_in      = 1'($urandom);
                start       = ($urandom_range(0, 2) == 0);
                cfg_pattern = 8'($urandom);
                cfg_len     = 4'($urandom);
                cfg_overlap = 1'($urandom);
                cfg_window  = 16'($urandom);
                tick();
                check({nm, " det@gap"}, detected, 0);
                check({nm, " done@gap"}, done, 0);
            end
            start     = 1'b0;
            bit_valid = 1'b1;
            bit_in    = stim[i];
            tick();
            exp_det = model_bit(stim[i], pat, len, ov);
            check({nm, " det"}, detected, 32'(exp_det));
            check({nm, " cnt"}, match_count, m_count);
            check({nm, " done"}, done, 32'(i == win - 1));
            check({nm, " busy"}, busy, 1);
        end
        bit_valid = 1'b0;
        tick();
        check({nm, " busy@end"}, busy, 0);
        check({nm, " done@end"}, done, 0);
        check({nm, " det@end"}, detected, 0);
        check({nm, " cnt@end"}, match_count, m_count);
        check({nm, " fvld@end"}, first_vld, 32'(m_fvld));
        if (m_fvld) check({nm, " fidx@end"}, first_idx, m_first);
        check({nm, " tmo@end"}, timeout, 0);
    endtask

    task automatic run_invalid(input string nm, input int unsigned len, input int unsigned win);
        do_start(8'hA5, len, 1'b1, win);
        check({nm, " done"}, done, 1);
        check({nm, " busy"}, busy, 1);
        check({nm, " cnt"}, match_count, 0);
        check({nm, " fvld"}, first_vld, 0);
        tick();
        check({nm, " busy@end"}, busy, 0);
        check({nm, " done@end"}, done, 0);
    endtask

    task automatic load(input logic [31:0] bits, input int unsigned n);
        stim.delete();
        for (int unsigned i = 0; i < n; i++) stim.push_back(bits[n - 1 - i]);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_window = '0;
        #23;
        check("rst busy", busy, 0);
        check("rst det", detected, 0);
        check("rst done", done, 0);
        check("rst cnt", match_count, 0);
        check("rst fvld", first_vld, 0);
        check("rst fidx", first_idx, 0);
        check("rst tmo", timeout, 0);
        rst = 1'b1;
        tick();

        load(32'b10101001, 8);
        run_case("ovl", 8'b101, 3, 1'b1, 8, 0);
        check("ovl cnt2", match_count, 2);
        check("ovl fidx2", first_idx, 2);

        run_invalid("len0", 0, 8);
        run_invalid("len9", 9, 8);
        run_invalid("win0", 3, 0);

        load(32'b10101101, 8);
        run_case("novl", 8'b101, 3, 1'b0, 8, 0);
        check("novl cnt2", match_count, 2);

        load(32'b10101001, 8);
        run_case("gap", 8'b101, 3, 1'b1, 8, 3);
        check("gap cnt2", match_count, 2);
        check("gap fidx2", first_idx, 2);

        load(32'b1, 1);
        run_case("w1", 8'b1, 1, 1'b0, 1, 0);

        stim.delete();
        for (int unsigned i = 0; i < 300; i++) stim.push_back(1'b1);
        run_case("sat", 8'b1, 1, 1'b1, 300, 0);
        check("sat cnt255", match_count, 255);

        for (int unsigned r = 0; r < 30; r++) begin
            int unsigned len = $urandom_range(1, 8);
            int unsigned win = $urandom_range(1, 40);
            logic [7:0]  pat = 8'($urandom);
            stim.delete();
            // Bias toward the pattern so matches actually occur.
            for (int unsigned i = 0; i < win; i++)
                stim.push_back(($urandom_range(0, 1) == 0) ? pat[len - 1 - (i % len)] : 1'($urandom));
            run_case("rnd", pat, len, 1'($urandom), win, $urandom_range(0, 3));
        end

        load(32'b101, 3);
        m_hist.delete();
        do_start(8'b101, 3, 1'b1, 100);
        for (int unsigned i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            bit_in    = stim[i];
            tick();
        end
        bit_valid = 1'b0;
        check("arst det pre", detected, 1);
        #2 rst = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst det", detected, 0);
        check("arst cnt", match_count, 0);
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            check("arst nodone", done, 0);
        end
        rst = 1'b1;
        tick();
        check("arst idle", busy, 0);

`ifdef SEQ_CTRL_TIMEOUT_EN
        begin
            int unsigned cyc = 0;
            do_start(8'b101, 3, 1'b1, 1000);
            while (!done && cyc < 200) begin
                tick();
                cyc++;
            end
            check("tmo cycles", cyc, 64);
            check("tmo flag", timeout, 1);
            check("tmo cnt", match_count, 0);
            tick();
            check("tmo busy@end", busy, 0);
            check("tmo hold", timeout, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
